// File: rtl/audio_i2s_tx.sv
// I2S stereo transmitter: derives MCLK/SCLK/LRCK from one free-running frame counter
// and shifts out a latched, attenuated left/right pair every frame.
module audio_i2s_tx #(
    parameter int SCLK_DIV_LOG2 = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] left_in,
    input  logic [15:0] right_in,
    input  logic        mute,
    input  logic [2:0]  vol,
    output logic        sample_req,
    output logic        mclk,
    output logic        lrck,
    output logic        sclk,
    output logic        sdata
);

    localparam int S = SCLK_DIV_LOG2;
    localparam int W = S + 6;

    logic [W-1:0] cnt;
    logic [15:0]  hold_l;
    logic [15:0]  hold_r;
    logic [15:0]  left_att;
    logic [15:0]  right_att;
    logic [15:0]  hold_cur;
    logic [4:0]   slot;
    logic [3:0]   bit_idx;
    logic         chan;
    logic         cnt_last;
    logic         bit_nxt;

    assign chan      = cnt[S+5];
    assign slot      = cnt[S+4:S];
    assign cnt_last  = &cnt;
    assign left_att  = $signed(left_in) >>> vol;
    assign right_att = $signed(right_in) >>> vol;

    // Slot 0 is the I2S one-bit delay; slots 1..16 carry the word MSB-first.
    always_comb begin
        hold_cur = chan ? hold_r : hold_l;
        bit_idx  = 4'(5'd16 - slot);
        bit_nxt  = 1'b0;
        if (slot != 5'd0 && slot <= 5'd16) begin
            bit_nxt = hold_cur[bit_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            hold_l <= '0;
            hold_r <= '0;
        end else if (!en) begin
            cnt    <= '0;
            hold_l <= '0;
            hold_r <= '0;
        end else begin
            cnt <= cnt + 1'b1;
            if (cnt_last) begin
                hold_l <= mute ? 16'h0000 : left_att;
                hold_r <= mute ? 16'h0000 : right_att;
            end
        end
    end

    // Every output is a one-clock-late decode of cnt so their relative phase is exact.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_req <= 1'b0;
            mclk       <= 1'b0;
            lrck       <= 1'b0;
            sclk       <= 1'b0;
            sdata      <= 1'b0;
        end else if (!en) begin
            sample_req <= 1'b0;
            mclk       <= 1'b0;
            lrck       <= 1'b0;
            sclk       <= 1'b0;
            sdata      <= 1'b0;
        end else begin
            sample_req <= (cnt == '0);
            mclk       <= cnt[1];
            lrck       <= chan;
            sclk       <= cnt[S-1];
            sdata      <= bit_nxt;
        end
    end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Directed bench for audio_i2s_tx: clock ratios, I2S word format, volume/mute latch timing,
// enable drop and asynchronous reset, with hand-computed expected words.
module tb_audio_i2s_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] left_in;
    logic [15:0] right_in;
    logic        mute;
    logic [2:0]  vol;
    logic        sample_req;
    logic        mclk;
    logic        lrck;
    logic        sclk;
    logic        sdata;
    logic [4:0]  outs;

    audio_i2s_tx #(.SCLK_DIV_LOG2(5)) dut (
        .clk(clk), .rst(rst), .en(en), .left_in(left_in), .right_in(right_in),
        .mute(mute), .vol(vol), .sample_req(sample_req), .mclk(mclk),
        .lrck(lrck), .sclk(sclk), .sdata(sdata)
    );

    always #5 clk = ~clk;
    assign outs = {sample_req, mclk, lrck, sclk, sdata};

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic        m;
        logic [2:0]  v;
        logic [15:0] el;
        logic [15:0] er;
    } vec_t;

    vec_t vecs[6];
    int checks = 0;
    int errors = 0;
    logic [31:0] sl;
    logic [31:0] sr;
    int n_sclk, n_mclk, n_lrr, n_lrf, n_req, req_at, glitch, lr_bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected per-slot bit vector (bit b = value in SCLK slot b) for a transmitted word.
    function automatic logic [31:0] slots_of(input logic [15:0] w);
        logic [31:0] s;
        s = '0;
        for (int b = 1; b <= 16; b++) s[b] = w[16-b];
        return s;
    endfunction

    task automatic wait_req(input string name);
        int k;
        k = 0;
        while (!sample_req && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check(name, {31'd0, sample_req}, 32'd1);
    endtask

    // Called at the negedge where sample_req is visible; returns one negedge into the next frame start.
    task automatic capture();
        logic ps, pm, pl, pd;
        int   ns;
        sl = '0; sr = '0;
        n_mclk = 0; n_lrr = 0; n_lrf = 0; n_req = 0; req_at = 0; glitch = 0; lr_bad = 0;
        ns = 0;
        ps = sclk; pm = mclk; pl = lrck; pd = sdata;
        for (int i = 1; i <= 2048; i++) begin
            @(negedge clk);
            if (sclk && !ps) begin
                if (ns < 32) sl[ns] = sdata;
                else if (ns < 64) sr[ns-32] = sdata;
                if (lrck !== (ns >= 32)) lr_bad++;
                ns++;
            end
            if (mclk && !pm) n_mclk++;
            if (lrck && !pl) n_lrr++;
            if (!lrck && pl) n_lrf++;
            if (sample_req) begin
                n_req++;
                req_at = i;
            end
            if (sdata !== pd && !(ps && !sclk)) glitch++;
            ps = sclk; pm = mclk; pl = lrck; pd = sdata;
        end
        n_sclk = ns;
    endtask

    task automatic apply_vec(input int i);
        left_in  = vecs[i].l;
        right_in = vecs[i].r;
        mute     = vecs[i].m;
        vol      = vecs[i].v;
    endtask

    initial begin
        int bad;
        vecs[0] = '{16'h8001, 16'h7FFE, 1'b0, 3'd0, 16'h8001, 16'h7FFE};
        vecs[1] = '{16'h8000, 16'h1234, 1'b0, 3'd3, 16'hF000, 16'h0246};
        vecs[2] = '{16'h4000, 16'hFFFF, 1'b0, 3'd7, 16'h0080, 16'hFFFF};
        vecs[3] = '{16'hABCD, 16'h5555, 1'b1, 3'd2, 16'h0000, 16'h0000};
        vecs[4] = '{16'h7FFF, 16'h8000, 1'b0, 3'd1, 16'h3FFF, 16'hC000};
        vecs[5] = '{16'h0001, 16'hFFFE, 1'b0, 3'd0, 16'h0001, 16'hFFFE};

        rst = 1'b1; en = 1'b0; left_in = '0; right_in = '0; mute = 1'b0; vol = '0;
        #3;
        check("reset_outputs", {27'd0, outs}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        bad = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (outs !== 5'd0) bad++;
        end
        check("idle_outputs", bad, 0);

        // Inputs present before the first latch; first frame after enable is zeros.
        apply_vec(0);
        en = 1'b1;
        wait_req("first_req");
        capture();
        check("ratio_sclk_per_frame", n_sclk, 64);
        check("ratio_mclk_per_frame", n_mclk, 512);
        check("ratio_lrck_rise", n_lrr, 1);
        check("ratio_lrck_fall", n_lrf, 1);
        check("req_count", n_req, 1);
        check("req_period", req_at, 2048);
        check("lrck_vs_slot", lr_bad, 0);
        check("first_frame_left", sl, 32'd0);
        check("first_frame_right", sr, 32'd0);

        for (int i = 0; i < 6; i++) begin
            if (i < 5) apply_vec(i + 1);
            capture();
            check($sformatf("vec%0d_left", i), sl, slots_of(vecs[i].el));
            check($sformatf("vec%0d_right", i), sr, slots_of(vecs[i].er));
            if (i == 0) check("sdata_on_sclk_fall", glitch, 0);
        end

        // Mute asserted mid-frame must not touch the frame in flight.
        left_in = 16'h1111; right_in = 16'h2222; mute = 1'b0; vol = 3'd0;
        capture();
        check("rehold_left", sl, slots_of(16'h0001));
        fork
            capture();
            begin
                repeat (1000) @(negedge clk);
                mute = 1'b1;
            end
        join
        check("mute_mid_left", sl, slots_of(16'h1111));
        check("mute_mid_right", sr, slots_of(16'h2222));
        fork
            capture();
            begin
                @(negedge clk);
                mute = 1'b0;
                left_in = 16'h4444;
                right_in = 16'h5555;
            end
        join
        check("muted_left", sl, 32'd0);
        check("muted_right", sr, 32'd0);
        fork
            capture();
            begin
                @(negedge clk);
                left_in = 16'h9999;
            end
        join
        check("unmute_left", sl, slots_of(16'h4444));
        check("unmute_right", sr, slots_of(16'h5555));
        capture();
        check("late_change_left", sl, slots_of(16'h9999));
        check("late_change_right", sr, slots_of(16'h5555));

        // Enable drop at slot 8 of the right channel.
        repeat (1290) @(negedge clk);
        check("drop_pre_lrck", {31'd0, lrck}, 32'd1);
        en = 1'b0;
        @(negedge clk);
        check("drop_outputs", {27'd0, outs}, 32'd0);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (outs !== 5'd0) bad++;
        end
        check("drop_idle", bad, 0);
        left_in = 16'h6666; right_in = 16'h7777;
        en = 1'b1;
        wait_req("reen_req");
        capture();
        check("reen_first_left", sl, 32'd0);
        check("reen_first_right", sr, 32'd0);
        capture();
        check("reen_second_left", sl, slots_of(16'h6666));
        check("reen_second_right", sr, slots_of(16'h7777));

        // Asynchronous reset mid-frame, away from any clock edge.
        repeat (1500) @(negedge clk);
        check("rst_pre_lrck", {31'd0, lrck}, 32'd1);
        #2 rst = 1'b1;
        #1 check("async_rst_outputs", {27'd0, outs}, 32'd0);
        @(negedge clk);
        check("rst_held_outputs", {27'd0, outs}, 32'd0);
        rst = 1'b0;
        wait_req("post_rst_req");
        capture();
        check("post_rst_left", sl, 32'd0);
        check("post_rst_right", sr, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
